mux_rr_n: RTL and testbench

- Parametrised successor to the team's combinational 16:1 byte mux.
- Selects one of CHANNELS WIDTH-bit input channels, each with its own valid/ready handshake, and delivers the selected word through a registered valid/ready output stage.
- Two modes: fixed (external select, as in the earlier mux) and round-robin scan over requesting channels.
- Sits between multiple producers and a single downstream consumer; it is the datapath funnel for multi-source buses.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/mux_rr_n_pick.sv | 39 +++
 rtl/mux_rr_n.sv | 106 ++++++++++
 tb/tb_mux_rr_n.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin channel mux family.
// Channel words are extracted from a flattened bus via chan_slice.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  // Upper bounds for the flattened bus and a single channel word.
  localparam int MAX_W   = 64;
  localparam int MAX_BUS = 2048;

  // Returns channel idx of a bus holding width-bit words, in the low bits.
  // Callers size-cast the result down to their own word width.
  function automatic logic [MAX_W-1:0] chan_slice(
    input logic [MAX_BUS-1:0] bus,
    input int unsigned        idx,
    input int unsigned        width
  );
    return MAX_W'(bus >> (idx * width));
  endfunction

endpackage

// File: rtl/mux_rr_n_pick.sv
// rr_pick_n: combinational priority search over req, starting at ptr and
// wrapping past CHANNELS-1 back to 0. Works for non-power-of-two sizes.
module rr_pick_n #(
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                any_grant
);

  localparam logic [SEL_W:0] CH_L = (SEL_W+1)'(CHANNELS);

  logic [SEL_W-1:0]    start;
  logic [CHANNELS-1:0] rotated;
  logic [SEL_W:0]      sum;

  assign start   = ({1'b0, ptr} < CH_L) ? ptr : '0;
  assign rotated = CHANNELS'({req, req} >> start);

  // Walk downwards so the lowest offset from start wins.
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    sum       = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sum       = {1'b0, start} + (SEL_W+1)'(k);
        any_grant = 1'b1;
      end
    end
    if (sum >= CH_L) begin
      sum = sum - CH_L;
    end
    grant = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/mux_rr_n.sv
// mux_rr_n: CHANNELS-to-1 funnel with fixed or round-robin selection and a
// registered valid/ready output stage. out_ready reaches in_ready combinationally.
module mux_rr_n
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          mux_sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  localparam int              PAD  = 1 << SEL_W;
  localparam logic [SEL_W:0]  CH_L = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  mode_t            mode_e;
  logic             can_load;
  logic             sel_ok;
  logic             fixed_hit;
  logic             rr_any;
  logic             any_grant;
  logic             xfer;
  logic             err_cond;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic [SEL_W-1:0] grant;
  logic [PAD-1:0]   valid_pad;
  logic [WIDTH-1:0] data_sel;

  assign mode_e    = mode_t'(mode);
  assign can_load  = !out_valid || out_ready;
  assign valid_pad = PAD'(in_valid);
  assign sel_ok    = {1'b0, mux_sel} < CH_L;
  assign fixed_hit = sel_ok && valid_pad[mux_sel];
  assign err_cond  = (mode_e == MODE_FIXED) && !sel_ok && (|in_valid);

  rr_pick_n #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .req      (in_valid),
    .ptr      (ptr),
    .grant    (rr_grant),
    .any_grant(rr_any)
  );

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    if (mode_e == MODE_RR) begin
      grant     = rr_grant;
      any_grant = rr_any;
    end else begin
      grant     = mux_sel;
      any_grant = fixed_hit;
    end
  end

  // Reset gating keeps in_ready low while the output stage is held clear.
  assign xfer = reset_n && any_grant && can_load;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (xfer && (grant == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  assign data_sel = WIDTH'(chan_slice(MAX_BUS'(data_in), 32'(grant), 32'(WIDTH)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      sel_err <= err_cond;
      if (xfer) begin
        data_out  <= data_sel;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode_e == MODE_RR) begin
          ptr <= (grant == LAST) ? '0 : grant + SEL_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Randomised bench for mux_rr_n against a queue-free behavioural model;
// a second CHANNELS=5 instance covers out-of-range select and odd wrap.
module tb_mux_rr_n;

  localparam int N   = 16;
  localparam int W   = 8;
  localparam int SW  = 4;
  localparam int N5  = 5;
  localparam int SW5 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            mode;
  logic [SW-1:0]   mux_sel;
  logic [N*W-1:0]  data_in;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    data_out;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;

  logic            reset5_n;
  logic            mode5;
  logic [SW5-1:0]  sel5;
  logic [N5*W-1:0] data5;
  logic [N5-1:0]   valid5;
  logic [N5-1:0]   ready5;
  logic [W-1:0]    dout5;
  logic [SW5-1:0]  chan5;
  logic            ovalid5;
  logic            ordy5;
  logic            err5;

  mux_rr_n dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .mux_sel(mux_sel),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_rr_n #(.WIDTH(W), .CHANNELS(N5)) dut5 (
    .clk(clk), .reset_n(reset5_n), .mode(mode5), .mux_sel(sel5),
    .data_in(data5), .in_valid(valid5), .in_ready(ready5),
    .data_out(dout5), .out_chan(chan5), .out_valid(ovalid5),
    .out_ready(ordy5), .sel_err(err5)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [W-1:0] ch[N];
  logic [W-1:0] ch5[N5];
  int           m_ptr;
  logic [W-1:0] m_data;
  int           m_chan;
  bit           m_valid;
  bit           m_err;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int model_grant();
    if (!mode) begin
      if (int'(mux_sel) < N && in_valid[mux_sel]) return int'(mux_sel);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_ptr = 0; m_data = '0; m_chan = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic applyStimulus(input bit md, input int sel, input logic [N-1:0] v,
                               input bit rdy);
    mode      = md;
    mux_sel   = SW'(sel);
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = ch[i];
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic runCycle(input string tag);
    int           g;
    bit           can_load;
    logic [N-1:0] exp_rdy;
    #1;
    g        = model_grant();
    can_load = !m_valid || out_ready;
    exp_rdy  = (g >= 0 && can_load) ? (N'(1) << g) : '0;
    checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    m_err = !mode && (int'(mux_sel) >= N) && (|in_valid);
    if (g >= 0 && can_load) begin
      m_data  = ch[g];
      m_chan  = g;
      m_valid = 1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    checkOutput({tag, ".data_out"},  64'(data_out),  64'(m_data));
    checkOutput({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    checkOutput({tag, ".sel_err"},   64'(sel_err),   64'(m_err));
  endtask

  initial begin
    reset_n  = 1'b0;
    reset5_n = 1'b0;
    mode5 = 1'b0; sel5 = '0; data5 = '0; valid5 = '0; ordy5 = 1'b1;
    for (int i = 0; i < N; i++) ch[i] = '0;
    modelReset();
    applyStimulus(0, 0, 16'hFFFF, 1);
    #1;
    checkOutput("rst.in_ready",  64'(in_ready),  64'h0);
    checkOutput("rst.out_valid", 64'(out_valid), 64'h0);
    checkOutput("rst.data_out",  64'(data_out),  64'h0);
    checkOutput("rst.out_chan",  64'(out_chan),  64'h0);
    checkOutput("rst.sel_err",   64'(sel_err),   64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    ch[5] = 8'hA5;
    applyStimulus(0, 5, 16'h0020, 1);
    runCycle("fix5");
    applyStimulus(0, 3, 16'h0010, 1);
    runCycle("fix3a");
    runCycle("fix3b");

    for (int i = 0; i < N; i++) ch[i] = W'(i);
    applyStimulus(1, 0, 16'hFFFF, 1);
    for (int k = 0; k < 17; k++) begin
      runCycle("rr_all");
      checkOutput("rr_all.seq", 64'(out_chan), 64'(k % N));
    end

    applyStimulus(1, 0, 16'h8001, 1);
    runCycle("rr_wrap0");
    checkOutput("rr_wrap0.seq", 64'(out_chan), 64'd15);
    runCycle("rr_wrap1");
    checkOutput("rr_wrap1.seq", 64'(out_chan), 64'd0);
    runCycle("rr_wrap2");
    checkOutput("rr_wrap2.seq", 64'(out_chan), 64'd15);

    ch[2] = 8'h5C; ch[3] = 8'hC3;
    applyStimulus(1, 0, 16'h0004, 1);
    runCycle("bp_load");
    applyStimulus(1, 0, 16'h0008, 0);
    for (int k = 0; k < 3; k++) begin
      runCycle("bp_stall");
      checkOutput("bp_stall.hold", 64'(data_out), 64'h5C);
    end
    applyStimulus(1, 0, 16'h0008, 1);
    runCycle("bp_release");
    checkOutput("bp_release.word", 64'(data_out), 64'hC3);

    applyStimulus(1, 0, 16'h0008, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("arst.out_valid", 64'(out_valid), 64'h0);
    checkOutput("arst.data_out",  64'(data_out),  64'h0);
    checkOutput("arst.in_ready",  64'(in_ready),  64'h0);
    modelReset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int it = 0; it < 300; it++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) ch[i] = W'($urandom);
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'(1) << $urandom_range(0, N - 1);
        2:       v = N'($urandom) & N'($urandom);
        default: v = N'($urandom);
      endcase
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), v,
                    $urandom_range(0, 9) < 7);
      runCycle("rnd");
    end

    for (int i = 0; i < N5; i++) ch5[i] = W'(8'h10 + 8'h11 * i);
    for (int i = 0; i < N5; i++) data5[i*W +: W] = ch5[i];
    reset5_n = 1'b1;
    mode5 = 1'b0; sel5 = 3'd6; valid5 = 5'b00001; ordy5 = 1'b1;
    #1;
    checkOutput("c5.err.in_ready", 64'(ready5), 64'h0);
    @(posedge clk); #1;
    checkOutput("c5.err.pulse",     64'(err5),    64'h1);
    checkOutput("c5.err.out_valid", 64'(ovalid5), 64'h0);
    valid5 = '0;
    @(posedge clk); #1;
    checkOutput("c5.err.clear",     64'(err5),    64'h0);
    checkOutput("c5.err.out_valid2", 64'(ovalid5), 64'h0);

    sel5 = 3'd0; valid5 = 5'b00001;
    #1;
    checkOutput("c5.fix.in_ready", 64'(ready5), 64'h1);
    @(posedge clk); #1;
    checkOutput("c5.fix.data", 64'(dout5), 64'(ch5[0]));

    mode5 = 1'b1; valid5 = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput("c5.rr.in_ready", 64'(ready5), 64'(N5'(1) << (k % N5)));
      @(posedge clk); #1;
      checkOutput("c5.rr.chan", 64'(chan5), 64'(k % N5));
      checkOutput("c5.rr.data", 64'(dout5), 64'(ch5[k % N5]));
    end

    #2;
    checkOutput("c5.pre_rst.out_valid", 64'(ovalid5), 64'h1);
    reset5_n = 1'b0;
    #1;
    checkOutput("c5.arst.out_valid", 64'(ovalid5), 64'h0);
    checkOutput("c5.arst.data_out",  64'(dout5),   64'h0);
    checkOutput("c5.arst.in_ready",  64'(ready5),  64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
